// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single valid/ready memory port.
// One transaction is in flight at a time; data wins unless it has hogged the port for MAX_DM_BURST grants.
module mem_port_arbiter #(
    parameter int MAX_DM_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wmask,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        stall
);

    localparam int SW = $clog2(MAX_DM_BURST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_reg, state_next;
    logic          grant_dm_reg;
    logic [SW-1:0] streak_reg, streak_next;
    logic          rw_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    wmask_reg;
    logic [31:0]   if_rdata_reg;
    logic [31:0]   dm_rdata_reg;

    logic take_grant;
    logic resp_capture;
    logic streak_full;
    logic dm_wins;

    // A pending fetch only overrides data once the data streak has saturated.
    assign streak_full = (streak_reg == SW'(MAX_DM_BURST));
    assign dm_wins     = dm_req & ~(streak_full & if_req);

    always_comb begin
        streak_next = streak_reg;
        if (dm_wins) begin
            if (!streak_full) begin
                streak_next = streak_reg + SW'(1);
            end
        end else begin
            streak_next = '0;
        end
    end

    always_comb begin
        state_next    = state_reg;
        take_grant    = 1'b0;
        resp_capture  = 1'b0;
        mem_req_valid = 1'b0;
        if_done       = 1'b0;
        dm_done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (if_req | dm_req) begin
                    take_grant = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    resp_capture = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if_done    = ~grant_dm_reg;
                dm_done    = grant_dm_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            grant_dm_reg <= 1'b0;
            streak_reg   <= '0;
            rw_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (take_grant) begin
                grant_dm_reg <= dm_wins;
                streak_reg   <= streak_next;
                if (dm_wins) begin
                    rw_reg    <= dm_we;
                    addr_reg  <= dm_addr;
                    wdata_reg <= dm_wdata;
                    wmask_reg <= dm_wmask;
                end else begin
                    rw_reg    <= 1'b0;
                    addr_reg  <= if_addr;
                    wdata_reg <= '0;
                    wmask_reg <= '0;
                end
            end
            // Store responses complete the handshake but carry no load data.
            if (resp_capture) begin
                if (!grant_dm_reg) begin
                    if_rdata_reg <= mem_resp_data;
                end else if (!rw_reg) begin
                    dm_rdata_reg <= mem_resp_data;
                end
            end
        end
    end

    assign mem_rw    = rw_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wmask = wmask_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign stall     = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant rule, burst counter, expected rdata).
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_wmask = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DM_BURST(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wmask(dm_wmask), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .stall(stall)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          streak_m = 0;
    logic [31:0] if_rdata_m = '0;
    logic [31:0] dm_rdata_m = '0;
    bit          last_dm_m;
    logic        last_obs_dm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle(input logic eid, input logic edd, input logic evalid);
        chk("if_done", 32'(if_done), 32'(eid));
        chk("dm_done", 32'(dm_done), 32'(edd));
        chk("mem_req_valid", 32'(mem_req_valid), 32'(evalid));
        chk("stall", 32'(stall), 32'((if_req & ~eid) | (dm_req & ~edd)));
    endtask

    task automatic chk_zero();
        chk("z_if_done", 32'(if_done), 32'd0);
        chk("z_dm_done", 32'(dm_done), 32'd0);
        chk("z_if_rdata", if_rdata, 32'd0);
        chk("z_dm_rdata", dm_rdata, 32'd0);
        chk("z_valid", 32'(mem_req_valid), 32'd0);
        chk("z_rw", 32'(mem_rw), 32'd0);
        chk("z_addr", mem_addr, 32'd0);
        chk("z_wdata", mem_wdata, 32'd0);
        chk("z_wmask", 32'(mem_wmask), 32'd0);
        chk("z_stall", 32'(stall), 32'd0);
    endtask

    task automatic set_if();
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic set_dm(input logic we, input logic [3:0] mask);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
        dm_wmask = mask;
    endtask

    task automatic to_idle();
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        chk_cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Called with requests already presented; exp_edges is the number of clock
    // edges until the command should appear (1 from IDLE, 2 from a DONE cycle).
    task automatic run_txn(input int exp_edges, input int rdy_dly, input int rsp_dly,
                           input bit spurious, input bit drop, input logic [31:0] word);
        bit          dm_win;
        logic        e_rw;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        int          edges;
        bit          seen;
        dm_win = dm_req && !(streak_m == MAX && if_req);
        if (dm_win) begin
            e_rw = dm_we; e_addr = dm_addr; e_wdata = dm_wdata; e_mask = dm_wmask;
            streak_m = (streak_m < MAX) ? streak_m + 1 : MAX;
        end else begin
            e_rw = 1'b0; e_addr = if_addr; e_wdata = '0; e_mask = 4'b0;
            streak_m = 0;
        end
        last_dm_m = dm_win;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 4) begin
            tick();
            edges++;
            seen = mem_req_valid;
            if (!seen) chk_cycle(1'b0, 1'b0, 1'b0);
        end
        chk("issue_latency", 32'(edges), 32'(exp_edges));
        if (!seen) return;
        for (int k = 0; k <= rdy_dly; k++) begin
            chk_cycle(1'b0, 1'b0, 1'b1);
            chk("issue_rw", 32'(mem_rw), 32'(e_rw));
            chk("issue_addr", mem_addr, e_addr);
            chk("issue_wmask", 32'(mem_wmask), 32'(e_mask));
            if (dm_win) chk("issue_wdata", mem_wdata, e_wdata);
            mem_req_ready  = (k == rdy_dly);
            mem_resp_valid = spurious;
            mem_resp_data  = ~word;
            tick();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        for (int k = 0; k <= rsp_dly; k++) begin
            chk_cycle(1'b0, 1'b0, 1'b0);
            chk("wait_addr", mem_addr, e_addr);
            mem_resp_valid = (k == rsp_dly);
            mem_resp_data  = (k == rsp_dly) ? word : ~word;
            if (k == rsp_dly && drop) begin
                if (dm_win) dm_req = 1'b0;
                else        if_req = 1'b0;
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        if (!dm_win)    if_rdata_m = word;
        else if (!e_rw) dm_rdata_m = word;
        last_obs_dm = dm_done;
        chk_cycle(~dm_win, dm_win, 1'b0);
        chk("if_rdata", if_rdata, if_rdata_m);
        chk("dm_rdata", dm_rdata, dm_rdata_m);
    endtask

    initial begin
        int  exp_e;
        bit  any;
        // Reset state
        tick();
        tick();
        chk_zero();
        rst = 1'b1;

        // Single fetch, minimum latency, known instruction word
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        run_txn(1, 0, 0, 1'b0, 1'b0, 32'h0050_0093);
        chk("fetch_word", if_rdata, 32'h0050_0093);
        to_idle();

        // Simultaneous fetch and load: load goes first, stall held until fetch done
        set_if();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000; dm_wmask = 4'b1111;
        run_txn(1, 0, 0, 1'b0, 1'b0, $urandom);
        chk("dm_first", 32'(last_obs_dm), 32'd1);
        dm_req = 1'b0;
        run_txn(2, 1, 1, 1'b0, 1'b0, $urandom);
        chk("if_second", 32'(last_obs_dm), 32'd0);
        to_idle();

        // Store held off by five not-ready cycles
        set_dm(1'b1, 4'b0011);
        run_txn(1, 5, 0, 1'b0, 1'b0, $urandom);
        to_idle();

        // Response during ISSUE must be ignored
        set_if();
        run_txn(1, 2, 1, 1'b1, 1'b0, $urandom);
        to_idle();

        // Requester withdraws mid-transaction
        set_dm(1'b0, 4'b1111);
        run_txn(1, 1, 2, 1'b0, 1'b1, $urandom);
        to_idle();

        // Burst limit: clear the streak, then keep both ports requesting
        rst = 1'b0;
        tick();
        rst = 1'b1;
        streak_m = 0; if_rdata_m = '0; dm_rdata_m = '0;
        chk_zero();
        set_if();
        set_dm(1'b0, 4'b1111);
        for (int j = 0; j < 6; j++) begin
            run_txn((j == 0) ? 1 : 2, 0, 0, 1'b0, 1'b0, $urandom);
            chk("burst_grant", 32'(last_obs_dm), (j == 4) ? 32'd0 : 32'd1);
            if (last_obs_dm) set_dm(1'b0, 4'b1111);
            else             set_if();
        end
        to_idle();

        // Reset while waiting for a response, late response afterwards
        set_dm(1'b0, 4'b1111);
        tick();
        chk("rw_issue", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("rw_wait", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        dm_req = 1'b0;
        streak_m = 0; if_rdata_m = '0; dm_rdata_m = '0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom | 32'h1;
        tick();
        mem_resp_valid = 1'b0;
        chk_zero();
        tick();
        chk_zero();

        // Randomized traffic
        set_dm($urandom_range(0, 1), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1) set_if();
        exp_e = 1;
        for (int i = 0; i < 40; i++) begin
            run_txn(exp_e, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom);
            if (last_dm_m) begin
                if ($urandom_range(0, 1) == 1) set_dm($urandom_range(0, 1), 4'($urandom_range(0, 15)));
                else dm_req = 1'b0;
                if (!if_req && $urandom_range(0, 2) == 0) set_if();
            end else begin
                if ($urandom_range(0, 1) == 1) set_if();
                else if_req = 1'b0;
                if (!dm_req && $urandom_range(0, 2) == 0)
                    set_dm($urandom_range(0, 1), 4'($urandom_range(0, 15)));
            end
            any = if_req || dm_req;
            if (any) begin
                exp_e = 2;
            end else begin
                for (int g = 0; g < $urandom_range(1, 3); g++) begin
                    tick();
                    chk_cycle(1'b0, 1'b0, 1'b0);
                end
                if ($urandom_range(0, 1) == 1) set_if();
                else set_dm($urandom_range(0, 1), 4'($urandom_range(0, 15)));
                exp_e = 1;
            end
        end
        to_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_DM_BURST, default 4, consecutive data-port grants allowed before a waiting fetch takes priority.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: if_req  input  1  fetch request; held by the requester until if_done.
REQ-005 Port: if_addr  input  32  fetch address.
REQ-006 Port: if_done  output  1  one-cycle pulse; fetch complete, if_rdata valid.
REQ-007 Port: if_rdata  output  32  fetched instruction; holds until the next if_done.
REQ-008 Port: dm_req, dm_we  input  1 each  data request; 1 = store, 0 = load; held until dm_done.
REQ-009 Port: dm_addr, dm_wdata  input  32 each  data address and store data.
REQ-010 Port: dm_wmask  input  4  store byte-enables.
REQ-011 Port: dm_done  output  1  one-cycle pulse; data access complete.
REQ-012 Port: dm_rdata  output  32  load data; holds until the next dm_done.
REQ-013 Port: mem_req_valid  output  1; mem_req_ready  input  1  memory command handshake.
REQ-014 Port: mem_rw  output  1 (1 = write); mem_addr, mem_wdata  output  32; mem_wmask  output  4  command fields.
REQ-015 Port: mem_resp_valid  input  1; mem_resp_data  input  32  response; one per command, stores included.
REQ-016 Port: stall  output  1  freeze request to the pipeline hazard logic.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-018 In IDLE with any request, the grant SHALL be latched and the FSM SHALL move to ISSUE on the next edge.
REQ-019 Arbitration SHALL be as follows: dm_req wins over if_req, unless dm_streak == MAX_DM_BURST and if_req = 1, in which case the fetch wins.
REQ-020 dm_streak SHALL increment, saturating at MAX_DM_BURST, on each data grant, and SHALL clear on each fetch grant.
REQ-021 The command fields SHALL be registered at grant and held stable for the whole transaction.
REQ-022 For fetch grants: mem_rw = 0 and mem_wmask = 0.
REQ-023 In ISSUE, mem_req_valid SHALL be 1.
REQ-024 In ISSUE: if mem_req_ready = 1, go to WAIT; otherwise stay in ISSUE with mem_req_valid and fields unchanged.
REQ-025 In WAIT, mem_req_valid SHALL be 0.
REQ-026 In WAIT, mem_resp_valid = 1 SHALL capture mem_resp_data into the granted port's rdata register and move the FSM to DONE.
REQ-027 mem_resp_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-028 In DONE, exactly one of if_done or dm_done SHALL be 1, matching the grant, and the FSM SHALL return to IDLE.
REQ-029 Minimum latency: request sampled at cycle T, ready at T+1, response at T+2, done at T+3, next grant decision at T+4.
REQ-030 dm_rdata SHALL NOT be updated by a store completion.
REQ-031 A request deasserted mid-transaction SHALL NOT abort the transaction; it completes and done still pulses.
REQ-032 stall SHALL be combinational: (if_req & ~if_done) | (dm_req & ~dm_done).
REQ-033 if_done and dm_done SHALL never be 1 in the same cycle.
REQ-034 mem_req_valid SHALL never be 1 outside ISSUE.

Reset
REQ-035 When rst = 0 at an edge, the block SHALL go to IDLE with dm_streak = 0, the grant cleared, and all outputs 0 (rdata and command registers = 0).
REQ-036 Reset SHALL take priority over any transition, including mid-ISSUE and mid-WAIT.
REQ-037 An outstanding transaction SHALL be dropped at reset, and a late response arriving in IDLE SHALL be ignored per REQ-027.

Verification
REQ-038 Scenario: if_req with if_addr = 0x100, ready at once, response 0x00500093 one cycle later -> if_done pulses 3 cycles after the request and if_rdata = 0x00500093.
REQ-039 Scenario: if_req and dm_req (load, 0x2000) both asserted in IDLE -> the load is issued first, dm_done precedes if_done, and stall stays 1 until if_done.
REQ-040 Scenario: MAX_DM_BURST = 4, dm_req held continuously with if_req pending -> 4 data grants, then 1 fetch grant, then dm_streak restarts at 1.
REQ-041 Scenario: store with wmask = 4'b0011 and mem_req_ready low for 5 cycles -> mem_req_valid and fields stable for all 6 cycles; dm_done pulses, dm_rdata unchanged.
REQ-042 Scenario: rst = 0 asserted while in WAIT, then mem_resp_valid = 1 after release -> no done pulse, FSM in IDLE, all outputs 0.
REQ-043 Scenario: mem_resp_valid = 1 while in ISSUE -> ignored; the transaction completes only on a response seen in WAIT.
